// File: rtl/alu_issue_seq_if.sv
// rtl/alu_issue_seq_if.sv - request, ALU-drive and result bundle for alu_issue_seq
interface alu_issue_seq_if #(
    parameter int CNT_W = 8
);
    // upstream request channel
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_use_acc;
    // registered drive into the combinational ALU and its answer
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_aluc;
    logic [3:0]       alu_r;
    logic             alu_zf;
    // downstream result channel
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_r;
    logic             out_zf;
    logic             out_err;
    // status
    logic [3:0]       acc;
    logic [CNT_W-1:0] op_cnt;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_acc, alu_r, alu_zf, out_ready,
        output in_ready, alu_a, alu_b, alu_aluc, out_valid, out_r, out_zf, out_err,
               acc, op_cnt
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_use_acc, alu_r, alu_zf, out_ready,
        input  in_ready, alu_a, alu_b, alu_aluc, out_valid, out_r, out_zf, out_err,
               acc, op_cnt
    );
endinterface

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/capture sequencer in front of the 4-bit ALU
module alu_issue_seq #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_fire;
    logic [3:0]       w_aluc;
    logic             w_err;

    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [3:0]       r_alu_aluc;
    logic             r_err;
    logic             r_out_valid;
    logic [3:0]       r_out_r;
    logic             r_out_zf;
    logic             r_out_err;
    logic [3:0]       r_acc;
    logic [CNT_W-1:0] r_op_cnt;

    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    // Translate the compact opcode into the ALU control; op 7 issues a harmless ADD and flags err
    always_comb begin
        w_aluc = 4'b0010;
        w_err  = 1'b0;
        case (bus.in_op)
            3'd0:    w_aluc = 4'b0010;
            3'd1:    w_aluc = 4'b0110;
            3'd2:    w_aluc = 4'b0000;
            3'd3:    w_aluc = 4'b0001;
            3'd4:    w_aluc = 4'b1101;
            3'd5:    w_aluc = 4'b1100;
            3'd6:    w_aluc = 4'b0111;
            default: w_err  = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and request-side ready; HOLD can hand over to a new request on the draining edge
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = EXEC;
            end
            EXEC: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) w_state_nxt = bus.in_valid ? EXEC : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand/control registers, result capture, accumulator and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_aluc  <= 4'b0010;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= 4'd0;
            r_out_zf    <= 1'b0;
            r_out_err   <= 1'b0;
            r_acc       <= 4'd0;
            r_op_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= bus.in_use_acc ? r_acc : bus.in_a;
                r_alu_b    <= bus.in_b;
                r_alu_aluc <= w_aluc;
                r_err      <= w_err;
            end
            if (r_state == EXEC) begin
                r_out_valid <= 1'b1;
                r_out_r     <= r_err ? 4'd0 : bus.alu_r;
                r_out_zf    <= r_err ? 1'b0 : bus.alu_zf;
                r_out_err   <= r_err;
                if (!r_err) r_acc <= bus.alu_r;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_op_cnt    <= r_op_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_aluc  = r_alu_aluc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out_r;
    assign bus.out_zf    = r_out_zf;
    assign bus.out_err   = r_out_err;
    assign bus.acc       = r_acc;
    assign bus.op_cnt    = r_op_cnt;
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed self-checking bench for alu_issue_seq
module tb_alu_issue_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_issue_seq_if #(.CNT_W(8)) ifc ();

    alu_issue_seq #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 4-bit ALU sitting behind the sequencer
    always_comb begin
        ifc.alu_r = 4'd0;
        case (ifc.alu_aluc)
            4'b0010: ifc.alu_r = ifc.alu_a + ifc.alu_b;
            4'b0110: ifc.alu_r = ifc.alu_a - ifc.alu_b;
            4'b0000: ifc.alu_r = ifc.alu_a & ifc.alu_b;
            4'b0001: ifc.alu_r = ifc.alu_a | ifc.alu_b;
            4'b1101: ifc.alu_r = ~(ifc.alu_a & ifc.alu_b);
            4'b1100: ifc.alu_r = ~(ifc.alu_a | ifc.alu_b);
            4'b0111: ifc.alu_r = ($signed(ifc.alu_a) < $signed(ifc.alu_b)) ? 4'd1 : 4'd0;
            default: ifc.alu_r = 4'd0;
        endcase
        ifc.alu_zf = (ifc.alu_r == 4'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc);
        ifc.in_valid   = 1'b1;
        ifc.in_op      = op;
        ifc.in_a       = a;
        ifc.in_b       = b;
        ifc.in_use_acc = use_acc;
    endtask

    task automatic idle_req();
        ifc.in_valid   = 1'b0;
        ifc.in_use_acc = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_op     = 3'd0;
        ifc.in_a      = 4'd0;
        ifc.in_b      = 4'd0;
        ifc.in_use_acc = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_aluc", ifc.alu_aluc, 4'b0010);
        chk("rst_alu_a", ifc.alu_a, 0);
        chk("rst_out_r", ifc.out_r, 0);
        chk("rst_acc", ifc.acc, 0);
        chk("rst_op_cnt", ifc.op_cnt, 0);
        chk("rst_in_ready", ifc.in_ready, 1);

        // ADD 7+9 wraps to 0, latency two edges
        req(3'd0, 4'd7, 4'd9, 1'b0);
        tick();
        idle_req();
        chk("add_alu_a", ifc.alu_a, 7);
        chk("add_alu_b", ifc.alu_b, 9);
        chk("add_aluc", ifc.alu_aluc, 4'b0010);
        chk("add_not_yet_valid", ifc.out_valid, 0);
        tick();
        chk("add_valid", ifc.out_valid, 1);
        chk("add_r", ifc.out_r, 0);
        chk("add_zf", ifc.out_zf, 1);
        chk("add_err", ifc.out_err, 0);
        chk("add_acc", ifc.acc, 0);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("add_drained", ifc.out_valid, 0);
        chk("add_op_cnt", ifc.op_cnt, 1);

        // SUB 5-3 then SLT 2<5 back-to-back on the HOLD edge
        req(3'd1, 4'd5, 4'd3, 1'b0);
        tick();
        idle_req();
        chk("sub_aluc", ifc.alu_aluc, 4'b0110);
        tick();
        chk("sub_valid", ifc.out_valid, 1);
        chk("sub_r", ifc.out_r, 2);
        chk("sub_zf", ifc.out_zf, 0);
        ifc.out_ready = 1'b1;
        req(3'd6, 4'd2, 4'd5, 1'b0);
        #1;
        chk("b2b_in_ready", ifc.in_ready, 1);
        tick();
        idle_req();
        chk("b2b_valid_low", ifc.out_valid, 0);
        chk("b2b_op_cnt", ifc.op_cnt, 2);
        chk("slt_aluc", ifc.alu_aluc, 4'b0111);
        tick();
        chk("slt_valid", ifc.out_valid, 1);
        chk("slt_r", ifc.out_r, 1);
        chk("slt_zf", ifc.out_zf, 0);
        tick();
        ifc.out_ready = 1'b0;
        chk("slt_op_cnt", ifc.op_cnt, 3);

        // accumulator chain: 3+4 -> 7, then acc+2 -> 9
        req(3'd0, 4'd3, 4'd4, 1'b0);
        tick();
        idle_req();
        tick();
        chk("chain1_r", ifc.out_r, 7);
        chk("chain1_acc", ifc.acc, 7);
        ifc.out_ready = 1'b1;
        req(3'd0, 4'd0, 4'd2, 1'b1);
        tick();
        idle_req();
        chk("chain2_alu_a", ifc.alu_a, 7);
        chk("chain2_op_cnt", ifc.op_cnt, 4);
        tick();
        chk("chain2_r", ifc.out_r, 9);
        chk("chain2_acc", ifc.acc, 9);
        tick();
        ifc.out_ready = 1'b0;
        chk("chain2_op_cnt_after", ifc.op_cnt, 5);

        // backpressure: NOR 0,0 = F held for 5 cycles, blocked request ignored
        req(3'd5, 4'd0, 4'd0, 1'b0);
        tick();
        idle_req();
        chk("nor_aluc", ifc.alu_aluc, 4'b1100);
        tick();
        req(3'd0, 4'd1, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", ifc.in_ready, 0);
            chk("bp_valid", ifc.out_valid, 1);
            chk("bp_r", ifc.out_r, 4'hF);
            chk("bp_zf", ifc.out_zf, 0);
            chk("bp_alu_a_stable", ifc.alu_a, 0);
            tick();
        end
        idle_req();
        chk("bp_op_cnt_held", ifc.op_cnt, 5);
        ifc.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", ifc.out_valid, 0);
        chk("bp_release_cnt", ifc.op_cnt, 6);
        tick();
        chk("bp_release_cnt_once", ifc.op_cnt, 6);
        ifc.out_ready = 1'b0;

        // set acc=6, then illegal op 7
        req(3'd0, 4'd2, 4'd4, 1'b0);
        tick();
        idle_req();
        tick();
        chk("pre_ill_acc", ifc.acc, 6);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("pre_ill_cnt", ifc.op_cnt, 7);
        req(3'd7, 4'd3, 4'd3, 1'b0);
        tick();
        idle_req();
        chk("ill_aluc", ifc.alu_aluc, 4'b0010);
        tick();
        chk("ill_valid", ifc.out_valid, 1);
        chk("ill_err", ifc.out_err, 1);
        chk("ill_r", ifc.out_r, 0);
        chk("ill_zf", ifc.out_zf, 0);
        chk("ill_acc", ifc.acc, 6);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("ill_op_cnt", ifc.op_cnt, 8);

        // reset while in EXEC discards the transaction
        req(3'd0, 4'd1, 4'd1, 1'b0);
        tick();
        idle_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", ifc.out_valid, 0);
        chk("mid_rst_acc", ifc.acc, 0);
        chk("mid_rst_cnt", ifc.op_cnt, 0);
        chk("mid_rst_in_ready", ifc.in_ready, 1);
        chk("mid_rst_aluc", ifc.alu_aluc, 4'b0010);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_spurious", ifc.out_valid, 0);
        end
        chk("mid_rst_cnt_stays", ifc.op_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
